// File: rtl/bcedn_unpool_pkg.sv
// Shared types and constant helpers for the B-CEDNet unpooling stage.
package bcedn_unpool_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAD_TOP,
    S_FILL,
    S_IDX,
    S_EMIT,
    S_PAD_BOT,
    S_DONE
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int grp_width(input int d, input int n_grp);
    return d / n_grp;
  endfunction

endpackage

// File: rtl/bcedn_line_buf.sv
// One pooled row of pixels plus their max-pool indices; data and index lanes
// have their own enables so the index can land a cycle after its pixel.
module bcedn_line_buf #(
  parameter int W  = 8,
  parameter int D  = 64,
  parameter int IW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          data_we,
  input  logic [AW-1:0] data_addr,
  input  logic [D-1:0]  data_wr,
  input  logic          idx_we,
  input  logic [AW-1:0] idx_addr,
  input  logic [IW-1:0] idx_wr,
  input  logic [AW-1:0] rd_addr,
  output logic [D-1:0]  rd_data,
  output logic [IW-1:0] rd_idx
);

  logic [IW+D-1:0] mem [W];

  always_ff @(posedge clk) begin
    if (data_we) mem[data_addr][D-1:0] <= data_wr;
    if (idx_we)  mem[idx_addr][IW+D-1:D] <= idx_wr;
  end

  assign rd_data = mem[rd_addr][D-1:0];
  assign rd_idx  = mem[rd_addr][IW+D-1:D];

endmodule

// File: rtl/bcedn_unpool_stream.sv
// Unpooling stage: buffers one pooled row with its indices, then streams the
// upsampled, zero-bordered rows out in raster order.
module bcedn_unpool_stream
  import bcedn_unpool_pkg::*;
#(
  parameter int H                = 8,
  parameter int W                = 8,
  parameter int D                = 64,
  parameter int POOL_H           = 2,
  parameter int POOL_W           = 2,
  parameter int N_GRP            = 4,
  parameter int PAD              = 1,
  parameter int MODE             = 0,
  parameter int INDEX_ADDR_WIDTH = $clog2(H*W)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic                                         in_en,
  output logic                                         in_rdy,
  input  logic [D-1:0]                                 data_in,
  output logic                                         pindex_rd,
  output logic [INDEX_ADDR_WIDTH-1:0]                  pindex_rd_addr,
  input  logic [clog2_min1(POOL_H*POOL_W)*N_GRP-1:0]   pindex_in,
  output logic                                         out_en,
  output logic [D-1:0]                                 data_out,
  output logic                                         done,
  output logic [2:0]                                   dbg_state
);

  localparam int PW   = clog2_min1(POOL_H*POOL_W);
  localparam int IW   = PW*N_GRP;
  localparam int GW   = grp_width(D, N_GRP);
  localparam int NWIN = POOL_H*POOL_W;
  localparam int OW   = W*POOL_W + 2*PAD;
  localparam int PADN = PAD*OW;
  localparam int RW   = clog2_min1(H);
  localparam int CW   = clog2_min1(W);
  localparam int SRW  = clog2_min1(POOL_H);
  localparam int SCW  = clog2_min1(POOL_W);
  localparam int OCW  = clog2_min1(OW);
  localparam int PCW  = clog2_min1(PADN + 1);

  state_t state, state_nxt;
  logic [RW-1:0]  r, r_nxt;
  logic [CW-1:0]  c, c_nxt;
  logic [SRW-1:0] sr, sr_nxt;
  logic [SCW-1:0] sc, sc_nxt;
  logic [OCW-1:0] oc, oc_nxt;
  logic [PCW-1:0] pcnt, pcnt_nxt;
  logic           idx_pend_q;
  logic [CW-1:0]  idx_addr_q;
  logic           xfer, interior;
  logic [D-1:0]   rd_data, pix;
  logic [IW-1:0]  rd_idx;

  // Handshake: a pixel transfers on a rising clk edge where in_en & in_rdy;
  // in_rdy depends on state only, so in_en outside FILL is simply ignored.
  assign in_rdy         = (state == S_FILL);
  assign xfer           = in_en & in_rdy;
  assign pindex_rd      = xfer;
  assign pindex_rd_addr = xfer ? INDEX_ADDR_WIDTH'(int'(r)*W + int'(c)) : '0;
  assign interior       = (int'(oc) >= PAD) && (int'(oc) < PAD + W*POOL_W);
  assign dbg_state      = state;

  bcedn_line_buf #(.W(W), .D(D), .IW(IW), .AW(CW)) u_line_buf (
    .clk       (clk),
    .data_we   (xfer),
    .data_addr (c),
    .data_wr   (data_in),
    .idx_we    (idx_pend_q),
    .idx_addr  (idx_addr_q),
    .idx_wr    (pindex_in),
    .rd_addr   (c),
    .rd_data   (rd_data),
    .rd_idx    (rd_idx)
  );

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    c_nxt     = c;
    sr_nxt    = sr;
    sc_nxt    = sc;
    oc_nxt    = oc;
    pcnt_nxt  = pcnt;
    case (state)
      S_IDLE: if (start) state_nxt = (PAD > 0) ? S_PAD_TOP : S_FILL;
      S_PAD_TOP: begin
        if (pcnt == PCW'(PADN-1)) begin
          pcnt_nxt  = '0;
          state_nxt = S_FILL;
        end else pcnt_nxt = pcnt + 1'b1;
      end
      S_FILL: begin
        if (xfer) begin
          if (c == CW'(W-1)) begin
            c_nxt     = '0;
            state_nxt = S_IDX;
          end else c_nxt = c + 1'b1;
        end
      end
      S_IDX: state_nxt = S_EMIT;
      S_EMIT: begin
        if (interior) begin
          if (sc == SCW'(POOL_W-1)) begin
            sc_nxt = '0;
            c_nxt  = c + 1'b1;
          end else sc_nxt = sc + 1'b1;
        end
        // End of one output line: next sub-row, or next pooled row.
        if (oc == OCW'(OW-1)) begin
          oc_nxt = '0;
          c_nxt  = '0;
          sc_nxt = '0;
          if (sr == SRW'(POOL_H-1)) begin
            sr_nxt = '0;
            if (r == RW'(H-1)) begin
              r_nxt     = '0;
              state_nxt = (PAD > 0) ? S_PAD_BOT : S_DONE;
            end else begin
              r_nxt     = r + 1'b1;
              state_nxt = S_FILL;
            end
          end else sr_nxt = sr + 1'b1;
        end else oc_nxt = oc + 1'b1;
      end
      S_PAD_BOT: begin
        if (pcnt == PCW'(PADN-1)) begin
          pcnt_nxt  = '0;
          state_nxt = S_DONE;
        end else pcnt_nxt = pcnt + 1'b1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A group passes its bits only when its index is in range and, in index
  // mode, points at the current window position.
  always_comb begin
    pix = '0;
    if (state == S_EMIT && interior) begin
      for (int g = 0; g < N_GRP; g++) begin
        if (int'(rd_idx[g*PW +: PW]) < NWIN &&
            (MODE == 1 || int'(rd_idx[g*PW +: PW]) == int'(sr)*POOL_W + int'(sc)))
          pix[g*GW +: GW] = rd_data[g*GW +: GW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      r          <= '0;
      c          <= '0;
      sr         <= '0;
      sc         <= '0;
      oc         <= '0;
      pcnt       <= '0;
      idx_pend_q <= 1'b0;
      idx_addr_q <= '0;
      out_en     <= 1'b0;
      data_out   <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      r          <= r_nxt;
      c          <= c_nxt;
      sr         <= sr_nxt;
      sc         <= sc_nxt;
      oc         <= oc_nxt;
      pcnt       <= pcnt_nxt;
      idx_pend_q <= xfer;
      idx_addr_q <= c;
      out_en     <= (state == S_PAD_TOP) || (state == S_EMIT) || (state == S_PAD_BOT);
      data_out   <= pix;
      done       <= (state == S_DONE);
    end
  end

endmodule

// File: tb/tb_bcedn_unpool_stream.sv
// Bench for bcedn_unpool_stream: three small configurations (index unpool,
// replicate, 3x1 window without border) checked against a frame-level model.
module tb_bcedn_unpool_stream;

  localparam int NK = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_v    [NK];
  logic       in_en_v    [NK];
  logic [3:0] data_in_v  [NK];
  logic [3:0] pindex_v   [NK];
  logic       in_rdy_v   [NK];
  logic       pindex_rd_v[NK];
  logic [1:0] addr_v     [NK];
  logic       out_en_v   [NK];
  logic [3:0] data_out_v [NK];
  logic       done_v     [NK];
  logic [2:0] dbg_v      [NK];

  // Per-configuration parameters and stimulus tables (pixel i = r*2+c).
  int         cfg_ph [NK];
  int         cfg_pw [NK];
  int         cfg_pad[NK];
  int         cfg_md [NK];
  logic [3:0] pix    [NK][4];
  logic [3:0] idx_tab[NK][4];
  bit         pat    [4];

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_q[$];
  int         exp_n, lat;
  logic [3:0] cap      [64];
  logic [3:0] cap_prev [64];
  int         cap_n, rd_cnt, done_cnt;
  int         act_k = 0;
  bit         chk_on = 1'b0;

  bcedn_unpool_stream #(.H(2), .W(2), .D(4), .POOL_H(2), .POOL_W(2), .N_GRP(2),
                        .PAD(1), .MODE(0)) u_dut_idx (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_en(in_en_v[0]), .in_rdy(in_rdy_v[0]),
    .data_in(data_in_v[0]), .pindex_rd(pindex_rd_v[0]), .pindex_rd_addr(addr_v[0]),
    .pindex_in(pindex_v[0]), .out_en(out_en_v[0]), .data_out(data_out_v[0]),
    .done(done_v[0]), .dbg_state(dbg_v[0]));

  bcedn_unpool_stream #(.H(2), .W(2), .D(4), .POOL_H(2), .POOL_W(2), .N_GRP(2),
                        .PAD(1), .MODE(1)) u_dut_rep (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_en(in_en_v[1]), .in_rdy(in_rdy_v[1]),
    .data_in(data_in_v[1]), .pindex_rd(pindex_rd_v[1]), .pindex_rd_addr(addr_v[1]),
    .pindex_in(pindex_v[1]), .out_en(out_en_v[1]), .data_out(data_out_v[1]),
    .done(done_v[1]), .dbg_state(dbg_v[1]));

  bcedn_unpool_stream #(.H(2), .W(2), .D(4), .POOL_H(3), .POOL_W(1), .N_GRP(2),
                        .PAD(0), .MODE(0)) u_dut_p31 (
    .clk(clk), .rst(rst), .start(start_v[2]), .in_en(in_en_v[2]), .in_rdy(in_rdy_v[2]),
    .data_in(data_in_v[2]), .pindex_rd(pindex_rd_v[2]), .pindex_rd_addr(addr_v[2]),
    .pindex_in(pindex_v[2]), .out_en(out_en_v[2]), .data_out(data_out_v[2]),
    .done(done_v[2]), .dbg_state(dbg_v[2]));

  // Index memory: answers one cycle after the read strobe, junk otherwise.
  always @(posedge clk)
    for (int k = 0; k < NK; k++)
      pindex_v[k] <= pindex_rd_v[k] ? idx_tab[k][int'(addr_v[k])] : 4'($urandom);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame model: each output position mapped straight back to its pooled pixel.
  task automatic build_expected(input int k);
    int ph, pw, pd, ow, oh, yy, xx, ig, wpos;
    logic [3:0] v, d, ix;
    ph = cfg_ph[k]; pw = cfg_pw[k]; pd = cfg_pad[k];
    ow = 2*pw + 2*pd;
    oh = 2*ph + 2*pd;
    exp_q.delete();
    for (int y = 0; y < oh; y++)
      for (int x = 0; x < ow; x++) begin
        v = 4'b0000;
        if (y >= pd && y < pd + 2*ph && x >= pd && x < pd + 2*pw) begin
          yy = y - pd;
          xx = x - pd;
          d  = pix[k][(yy/ph)*2 + xx/pw];
          ix = idx_tab[k][(yy/ph)*2 + xx/pw];
          wpos = (yy % ph)*pw + (xx % pw);
          for (int g = 0; g < 2; g++) begin
            ig = int'(ix[2*g +: 2]);
            if (ig < ph*pw && (cfg_md[k] == 1 || ig == wpos)) v[2*g +: 2] = d[2*g +: 2];
          end
        end
        exp_q.push_back(v);
      end
    exp_n = oh*ow;
    lat   = 1 + pd*ow*2 + 2*(2 + 1 + ph*ow) + 1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      if (out_en_v[act_k]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_output actual=%0h expected=none t=%0t", data_out_v[act_k], $time);
        end else check("pixel", data_out_v[act_k], exp_q.pop_front());
        if (cap_n < 64) cap[cap_n] = data_out_v[act_k];
        cap_n++;
      end else check("idle_zero", data_out_v[act_k], 0);
      if (done_v[act_k]) done_cnt++;
      if (pindex_rd_v[act_k]) rd_cnt++;
    end
  end

  task automatic check_zero(input int k);
    check("rst_in_rdy", in_rdy_v[k], 0);
    check("rst_pindex_rd", pindex_rd_v[k], 0);
    check("rst_addr", addr_v[k], 0);
    check("rst_out_en", out_en_v[k], 0);
    check("rst_data_out", data_out_v[k], 0);
    check("rst_done", done_v[k], 0);
  endtask

  task automatic run_frame(input int k, input bit gap, input int extra_start_at, input bit check_lat);
    int i, t0;
    bit got_done;
    i = 0;
    got_done = 1'b0;
    act_k = k;
    build_expected(k);
    cap_n = 0; rd_cnt = 0; done_cnt = 0;
    chk_on = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b1;
    t0 = cyc;
    for (int n = 0; n < 400 && !got_done; n++) begin
      @(posedge clk); #1;
      start_v[k] = (n == extra_start_at);
      if (i >= 4) begin
        in_en_v[k]   = 1'b1;
        data_in_v[k] = 4'($urandom);
      end else if (!gap || pat[n % 4]) begin
        in_en_v[k]   = 1'b1;
        data_in_v[k] = pix[k][i];
      end else begin
        in_en_v[k]   = 1'b0;
        data_in_v[k] = 4'($urandom);
      end
      @(negedge clk);
      if (in_en_v[k] && in_rdy_v[k]) begin
        check("rd_strobe", pindex_rd_v[k], 1);
        check("rd_addr", addr_v[k], i);
        i++;
      end
      if (done_v[k]) begin
        got_done = 1'b1;
        if (check_lat) check("done_latency", cyc - t0, lat);
      end
    end
    check("done_seen", got_done, 1);
    repeat (3) @(negedge clk);
    in_en_v[k] = 1'b0;
    check("out_count", cap_n, exp_n);
    check("exp_left", exp_q.size(), 0);
    check("done_pulses", done_cnt, 1);
    check("rd_count", rd_cnt, 4);
  endtask

  initial begin
    int n1010, nzero, ndiff;
    cfg_ph  = '{2, 2, 3};
    cfg_pw  = '{2, 2, 1};
    cfg_pad = '{1, 1, 0};
    cfg_md  = '{0, 1, 0};
    pix[0] = '{4'b1111, 4'b0110, 4'b1001, 4'b1111};
    idx_tab[0] = '{4'b1100, 4'b0110, 4'b0001, 4'b1010};
    pix[1] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010};
    idx_tab[1] = '{4'b0000, 4'b0101, 4'b1010, 4'b1111};
    pix[2] = '{4'b1111, 4'b1011, 4'b0101, 4'b1110};
    idx_tab[2] = '{4'b0111, 4'b1000, 4'b1111, 4'b0110};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < NK; k++) begin
      start_v[k] = 1'b0;
      in_en_v[k] = 1'b0;
      data_in_v[k] = 4'b0000;
    end

    // Power-on reset.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NK; k++) check_zero(k);
    @(posedge clk); #1;
    rst = 1'b0;

    // Index unpool frame with hand-computed pins.
    run_frame(0, 1'b0, -1, 1'b1);
    check("a_r1c1", cap[7], 4'b0011);
    check("a_r2c2", cap[14], 4'b1100);
    check("a_r1c2", cap[8], 4'b0000);
    check("a_corner", cap[0], 4'b0000);

    // Reset mid-row, then a clean frame.
    chk_on = 1'b0;
    act_k = 0;
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    in_en_v[0] = 1'b1;
    data_in_v[0] = 4'b0101;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero(0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    in_en_v[0] = 1'b0;
    @(negedge clk);
    check_zero(0);
    run_frame(0, 1'b0, -1, 1'b1);

    // Replicate mode.
    run_frame(1, 1'b0, -1, 1'b1);
    n1010 = 0;
    nzero = 0;
    for (int j = 0; j < 36; j++) begin
      if (cap[j] == 4'b1010) n1010++;
      if (cap[j] == 4'b0000) nzero++;
    end
    check("rep_interior", n1010, 16);
    check("rep_border", nzero, 20);

    // 3x1 window, no border, out-of-range index on group 0 of pixel (0,0).
    run_frame(2, 1'b0, -1, 1'b1);
    check("p31_sr0", cap[0], 4'b0000);
    check("p31_sr1", cap[2], 4'b1100);
    check("p31_sr2", cap[4], 4'b0000);

    // Gapped input with in_en held high outside FILL.
    run_frame(0, 1'b1, -1, 1'b0);

    // Stray start during EMIT, then an identical second frame.
    run_frame(0, 1'b0, 12, 1'b1);
    for (int j = 0; j < 64; j++) cap_prev[j] = cap[j];
    run_frame(0, 1'b0, -1, 1'b1);
    ndiff = 0;
    for (int j = 0; j < 36; j++) if (cap[j] !== cap_prev[j]) ndiff++;
    check("repeat_frame", ndiff, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
